// File: rtl/quadrature_decoder.sv
// Quadrature (A/B) receiver: synchronises and glitch-filters both channels,
// decodes each Gray-code step into a one-cycle direction pulse, keeps a
// wrapping two's-complement position count and a sticky illegal-jump flag.
//
// FSM states
//   state  | meaning
//   S_INIT | pipeline settling: filtered levels and prev_ab track the synced
//          | inputs directly, no steps decoded, position held
//   S_RUN  | normal decoding of filtered A/B against the previous sample
module quadrature_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 A,
    input  logic                 B,
    input  logic                 clear,
    input  logic                 err_clr,
    output logic                 step_cw,
    output logic                 step_ccw,
    output logic                 dir,
    output logic [CNT_WIDTH-1:0] position,
    output logic                 err
);

    // Filter counter only needs to reach FILTER_CYCLES-1; keep at least one bit.
    localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_CYCLES - 1);

    // INIT lasts long enough for a level present at reset release to reach
    // the filtered registers, so RUN never starts with a stale comparison.
    localparam int INIT_LEN = SYNC_STAGES + FILTER_CYCLES;
    localparam int ICW      = $clog2(INIT_LEN);
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_LEN - 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                 r_state;
    logic [ICW-1:0]         r_init_cnt;
    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             r_f;          // filtered {A,B}
    logic [FCW-1:0]         r_fcnt [2];   // per-channel disagreement counters
    logic [1:0]             r_prev_ab;
    logic                   r_step_cw;
    logic                   r_step_ccw;
    logic                   r_dir;
    logic [CNT_WIDTH-1:0]   r_position;
    logic                   r_err;

    logic [1:0] w_s;        // synced {A,B}
    logic [1:0] w_delta;    // phase advance from prev_ab to filtered value

    // Map a Gray-coded AB pair to its position in the clockwise cycle
    // 00 -> 10 -> 11 -> 01, so a step is just a difference modulo 4.
    function automatic logic [1:0] gray_to_phase(input logic [1:0] ab);
        logic [1:0] ph;
        ph = 2'd0;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    assign w_s     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    assign w_delta = gray_to_phase(r_f) - gray_to_phase(r_prev_ab);

    // Synchroniser chains for the asynchronous channel inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], A};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], B};
        end
    end

    // Per-channel glitch filter: a new level must persist FILTER_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_state == S_INIT) begin
                    r_f[i]    <= w_s[i];
                    r_fcnt[i] <= '0;
                end else if (w_s[i] == r_f[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FC_LAST) begin
                    r_f[i]    <= w_s[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end
        end
    end

    // Sequencing FSM with step decode, position counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_prev_ab  <= '0;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_dir      <= 1'b0;
            r_position <= '0;
            r_err      <= 1'b0;
        end else begin
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            if (err_clr) begin
                r_err <= 1'b0;
            end
            if (clear) begin
                r_position <= '0;
            end
            case (r_state)
                S_INIT: begin
                    r_prev_ab <= w_s;
                    if (r_init_cnt == INIT_LAST) begin
                        r_state <= S_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + ICW'(1);
                    end
                end
                default: begin
                    r_prev_ab <= r_f;
                    case (w_delta)
                        2'd1: begin
                            r_step_cw <= 1'b1;
                            r_dir     <= 1'b1;
                            if (!clear) begin
                                r_position <= r_position + CNT_ONE;
                            end
                        end
                        2'd3: begin
                            r_step_ccw <= 1'b1;
                            r_dir      <= 1'b0;
                            if (!clear) begin
                                r_position <= r_position - CNT_ONE;
                            end
                        end
                        2'd2: begin
                            // A two-bit jump has no defined direction; flag it
                            // and leave position/dir untouched. Beats err_clr.
                            r_err <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

    assign step_cw  = r_step_cw;
    assign step_ccw = r_step_ccw;
    assign dir      = r_dir;
    assign position = r_position;
    assign err      = r_err;

endmodule
